// File: rtl/abs_pkg.sv
// rtl/abs_pkg.sv - shared constants and result type for the absolute-value arbiter
package abs_pkg;

  localparam int ABS_W = 16;
  localparam int CHAN_W = 3;
  localparam logic [ABS_W-1:0] SAT_MAX = 16'h7FFF;

  typedef struct packed {
    logic [ABS_W-1:0]  data;
    logic [CHAN_W-1:0] chan;
    logic              sat;
  } res_t;

endpackage

// File: rtl/abs_arbiter_rr.sv
// rtl/abs_arbiter_rr.sv - combinational round-robin grant selection
// The search begins at ptr_i and wraps; the first active request wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [CW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/abs_arbiter.sv
// rtl/abs_arbiter.sv - round-robin shared absolute-value unit with saturation count
// One result register; a new grant is only issued when that register is free or draining.
module abs_arbiter
  import abs_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ABS_W
) (
  input  logic                      iclk,
  input  logic                      irst,
  input  logic [NREQ-1:0]           ivalid,
  input  logic [NREQ*W-1:0]         idata,
  output logic [NREQ-1:0]           iready,
  output logic                      ovalid,
  output logic [W-1:0]              odata,
  output logic [$clog2(NREQ)-1:0]   ochan,
  output logic                      osat,
  input  logic                      ordy,
  output logic [15:0]               osatcnt
);

  localparam int CW = $clog2(NREQ);

  logic            ovalid_q;
  res_t            res_q, res_d;
  logic [15:0]     satcnt_q;
  logic [CW-1:0]   ptr_q;
  logic [CW-1:0]   gidx;
  logic            free;
  logic            xfer;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    sample;
  logic            is_min;

  assign free = !ovalid_q || ordy;
  assign req  = (free && !irst) ? ivalid : '0;

  rr_arbiter #(.N(NREQ), .CW(CW)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign iready = gnt;
  assign xfer   = |gnt;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gidx = CW'(i);
    end
  end

  assign sample = idata[gidx*W +: W];
  // The most-negative value has no positive twin at width W, so it clamps.
  assign is_min = (sample == {1'b1, {(W-1){1'b0}}});

  always_comb begin
    res_d.chan = CHAN_W'(gidx);
    res_d.sat  = is_min;
    if (is_min)
      res_d.data = SAT_MAX;
    else if (sample[W-1])
      res_d.data = ABS_W'(-sample);
    else
      res_d.data = ABS_W'(sample);
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      ovalid_q <= 1'b0;
      res_q    <= '0;
      satcnt_q <= '0;
      ptr_q    <= '0;
    end else if (xfer) begin
      ovalid_q <= 1'b1;
      res_q    <= res_d;
      ptr_q    <= (gidx == CW'(NREQ-1)) ? '0 : gidx + CW'(1);
      if (res_d.sat && satcnt_q != 16'hFFFF)
        satcnt_q <= satcnt_q + 16'd1;
    end else if (ordy) begin
      ovalid_q <= 1'b0;
    end
  end

  assign ovalid  = ovalid_q;
  assign odata   = W'(res_q.data);
  assign ochan   = CW'(res_q.chan);
  assign osat    = res_q.sat;
  assign osatcnt = satcnt_q;

endmodule

// File: tb/tb_abs_arbiter.sv
// tb/tb_abs_arbiter.sv - randomized scoreboard bench for abs_arbiter
module tb_abs_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              iclk = 1'b0;
  logic              irst;
  logic [NREQ-1:0]   ivalid;
  logic [NREQ*W-1:0] idata;
  logic [NREQ-1:0]   iready;
  logic              ovalid;
  logic [W-1:0]      odata;
  logic [1:0]        ochan;
  logic              osat;
  logic              ordy;
  logic [15:0]       osatcnt;

  abs_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .iclk    (iclk),
    .irst    (irst),
    .ivalid  (ivalid),
    .idata   (idata),
    .iready  (iready),
    .ovalid  (ovalid),
    .odata   (odata),
    .ochan   (ochan),
    .osat    (osat),
    .ordy    (ordy),
    .osatcnt (osatcnt)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int data;
    int chan;
    int sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference state: last granted index, whether the output slot is full, saturation count
  int   m_last  = NREQ - 1;
  bit   m_valid = 1'b0;
  int   m_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model();
    logic [NREQ-1:0]     g;
    int                  pick;
    int                  idx;
    logic signed [W-1:0] s;
    int                  xi;
    exp_t                e;
    g    = '0;
    pick = -1;
    chk("osatcnt", 32'(osatcnt), 32'(m_cnt));
    if (!irst && (!m_valid || ordy)) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (ivalid[idx]) begin
          pick = idx;
          break;
        end
      end
    end
    if (pick >= 0) g[pick] = 1'b1;
    chk("iready", 32'(iready), 32'(g));
    if (irst) begin
      m_valid = 1'b0;
      m_last  = NREQ - 1;
      m_cnt   = 0;
    end else if (pick >= 0) begin
      s  = idata[pick*W +: W];
      xi = int'(s);
      e.chan = pick;
      if (xi == -32768) begin
        e.data = 32767;
        e.sat  = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        e.data = (xi < 0) ? -xi : xi;
        e.sat  = 0;
      end
      sb.push_back(e);
      m_valid = 1'b1;
      m_last  = pick;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit rst, input logic [NREQ-1:0] v,
                      input logic [NREQ*W-1:0] d, input bit rdy);
    @(negedge iclk);
    irst   = rst;
    ivalid = v;
    idata  = d;
    ordy   = rdy;
    #1;
    model();
  endtask

  function automatic logic [NREQ*W-1:0] rand_data();
    logic [NREQ*W-1:0] d;
    for (int l = 0; l < NREQ; l++)
      d[l*W +: W] = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
    return d;
  endfunction

  // monitor: pops a new expectation whenever the output slot was free at the last edge
  initial begin
    bit   prev_valid;
    exp_t cur;
    prev_valid = 1'b0;
    cur = '{data: 0, chan: 0, sat: 0};
    forever begin
      @(posedge iclk);
      #2;
      if (irst) begin
        chk("rst_ovalid", 32'(ovalid), 0);
        chk("rst_odata", 32'(odata), 0);
        chk("rst_ochan", 32'(ochan), 0);
        chk("rst_osat", 32'(osat), 0);
        prev_valid = 1'b0;
      end else begin
        if (ovalid) begin
          if (!prev_valid || ordy) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) cur = sb.pop_front();
          end
          chk("odata", 32'(odata), 32'(cur.data));
          chk("ochan", 32'(ochan), 32'(cur.chan));
          chk("osat", 32'(osat), 32'(cur.sat));
        end else begin
          chk("ovalid_drop", 32'(prev_valid && !ordy), 0);
          chk("sb_pending", 32'(sb.size()), 0);
        end
        prev_valid = ovalid;
      end
    end
  end

  initial begin
    logic [NREQ*W-1:0] d;
    int                seq[8];
    irst   = 1'b1;
    ivalid = '0;
    idata  = '0;
    ordy   = 1'b0;

    step(1, '0, '0, 0);
    step(1, '0, '0, 0);

    step(0, 4'b0001, {48'h0, 16'h0003}, 1);
    step(0, '0, '0, 1);

    d = '0;
    d[2*W +: W] = 16'hFFFF;
    step(0, 4'b0100, d, 1);
    d[2*W +: W] = 16'h8000;
    step(0, 4'b0100, d, 1);
    step(0, '0, '0, 1);
    chk("satcnt_one", 32'(osatcnt), 1);

    step(1, '0, '0, 1);
    seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int k = 0; k < 8; k++) begin
      step(0, 4'b1111, rand_data(), 1);
      chk("rr_seq", 32'(iready), 32'(1 << seq[k]));
    end

    step(0, 4'b1111, rand_data(), 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 4'b1111, rand_data(), 0);
      chk("stall_iready", 32'(iready), 0);
    end
    step(0, 4'b1111, rand_data(), 1);
    chk("drain_regrant", 32'(iready != 0), 1);

    step(0, 4'b0010, rand_data(), 1);
    step(0, 4'b1010, rand_data(), 0);
    step(1, 4'b1010, rand_data(), 0);
    step(0, 4'b1010, rand_data(), 1);
    chk("post_rst_grant", 32'(iready), 32'(4'b0010));

    for (int k = 0; k < 400; k++)
      step(($urandom_range(63) == 0), 4'($urandom), rand_data(), ($urandom_range(3) != 0));
    step(0, '0, '0, 1);

    step(1, '0, '0, 1);
    for (int k = 0; k < 65537; k++)
      step(0, 4'b1111, {4{16'h8000}}, 1);
    step(0, '0, '0, 1);
    step(0, '0, '0, 1);
    chk("satcnt_sticky", 32'(osatcnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abs_arbiter.md
ABS_ARBITER -- requirements
Module: abs_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the absolute-value datapath; legal range 2..8.
REQ-002 Parameter W, default 16: sample width, two's complement.
REQ-003 iclk  input  1: the single clock; all state updates on its rising edge.
REQ-004 irst  input  1: synchronous, active-high reset.
REQ-005 ivalid  input  NREQ: per-requester sample valid.
REQ-006 idata  input  NREQ*W: packed per-requester samples; requester i occupies bits [i*W +: W].
REQ-007 iready  output  NREQ: per-requester accept; at most one bit high per cycle.
REQ-008 ovalid  output  1: result valid.
REQ-009 odata  output  W: absolute value of the accepted sample.
REQ-010 ochan  output  $clog2(NREQ): index of the requester that produced odata.
REQ-011 osat  output  1: odata was saturated; qualified by ovalid.
REQ-012 ordy  input  1: downstream accept for odata.
REQ-013 osatcnt  output  16: running count of saturated results.

Function
REQ-014 The output stage is free when ovalid is low, or when ovalid and ordy are both high.
REQ-015 A grant is issued only when the output stage is free and at least one ivalid bit is high.
REQ-016 Grant is round-robin: search starts at last-granted index + 1 modulo NREQ; after reset the search starts at index 0.
REQ-017 iready[i] is high exactly in a cycle where requester i holds the grant; it is combinational from ivalid, ordy and state.
REQ-018 Transfer occurs when ivalid[i] and iready[i] are both high at a rising edge; the last-grant pointer updates only on a transfer.
REQ-019 Latency: a sample transferred at edge N appears on odata/ochan/osat with ovalid high immediately after edge N, i.e. one cycle.
REQ-020 Transfer and output drain in the same cycle are legal, giving back-to-back throughput of one result per cycle.
REQ-021 While ovalid is high and ordy is low, odata, ochan and osat hold stable and no iready is asserted.
REQ-022 ovalid clears after a drain edge that has no new transfer.
REQ-023 odata = x when x >= 0, and -x when x < 0, computed at width W.
REQ-024 The most-negative input (0x8000 at W=16) saturates to 0x7FFF with osat high; osat is low for every other input.
REQ-025 osatcnt increments by one on each transfer whose result saturates, and sticks at 0xFFFF with no wrap.
REQ-026 A requester dropping ivalid without a transfer loses nothing; no sample is ever dropped or duplicated.

Reset
REQ-027 With irst high at an edge: ovalid=0, odata=0, ochan=0, osat=0, osatcnt=0, and the round-robin pointer is set so the next search starts at index 0.
REQ-028 iready is all-zero for every cycle in which irst is high.
REQ-029 Reset mid-operation discards any pending result; a result held against ordy low is not presented after reset.

Structure
REQ-030 The following belong in a shared package (abs_pkg): the sample width constant, the saturated-maximum constant, and the result struct {data, chan, sat}.
REQ-031 Grant selection is one sub-module, rr_arbiter (request vector and pointer in, one-hot grant out, purely combinational); all registers live in abs_arbiter.

Verification
REQ-032 Single requester 0 sends 0x0003, ordy=1 -> next cycle ovalid=1, odata=0x0003, ochan=0, osat=0.
REQ-033 Requester 2 sends 0xFFFF -> odata=0x0001, ochan=2; then it sends 0x8000 -> odata=0x7FFF, osat=1, osatcnt=1.
REQ-034 All 4 ivalid held high with ordy=1 for 8 cycles -> ochan sequence 0,1,2,3,0,1,2,3, one result per cycle.
REQ-035 ovalid high with ordy held low for 3 cycles while requests are pending -> iready=0 and odata/ochan unchanged; ordy=1 -> drain and new grant in the same cycle.
REQ-036 irst asserted while ovalid=1 and ordy=0 -> next cycle ovalid=0, osatcnt=0, and the first post-reset grant goes to the lowest active index.
REQ-037 65537 saturating inputs -> osatcnt=0xFFFF, with no wrap.
